// File: rtl/rps_match_if.sv
// Player inputs and display/score outputs of the rock-paper-scissors match controller.
// The slave modport is the controller side; the master modport is the board/driver side.
interface rps_match_if;
  logic [2:0] p1_i;
  logic [2:0] p2_i;
  logic       new_game_i;
  logic [2:0] state_o;
  logic [2:0] disp_sel_o;
  logic [2:0] disp_data_o;
  logic [3:0] p1_score_o;
  logic [3:0] p2_score_o;
  logic       game_over_o;

  modport master (
    output p1_i,
    output p2_i,
    output new_game_i,
    input  state_o,
    input  disp_sel_o,
    input  disp_data_o,
    input  p1_score_o,
    input  p2_score_o,
    input  game_over_o
  );

  modport slave (
    input  p1_i,
    input  p2_i,
    input  new_game_i,
    output state_o,
    output disp_sel_o,
    output disp_data_o,
    output p1_score_o,
    output p2_score_o,
    output game_over_o
  );
endinterface

// File: rtl/rps_match_ctrl.sv
// Rock-paper-scissors match controller: debounced move capture on a slow tick, timed reveal
// of both moves and the result, score keeping up to a win target, and a game-over hold.
module rps_match_ctrl #(
  parameter int unsigned TICK_DIV     = 208000,
  parameter int unsigned STABLE_TICKS = 3,
  parameter int unsigned SHOW_TICKS   = 5,
  parameter int unsigned WIN_TARGET   = 3
) (
  input  logic        clk_i,
  input  logic        reset_n,
  rps_match_if.slave  bus
);

  localparam int unsigned TickW  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned StabW  = $clog2(STABLE_TICKS + 1);
  localparam int unsigned PhaseW = (SHOW_TICKS > 1) ? $clog2(SHOW_TICKS) : 1;

  localparam logic [3:0] WinTgt   = 4'(WIN_TARGET);
  localparam logic [2:0] Rock     = 3'b001;
  localparam logic [2:0] Paper    = 3'b010;
  localparam logic [2:0] Scissors = 3'b100;
  localparam logic [2:0] ResP1    = 3'b001;
  localparam logic [2:0] ResP2    = 3'b010;
  localparam logic [2:0] ResDraw  = 3'b100;

  typedef enum logic [2:0] {
    StRelease = 3'd0,
    StCollect = 3'd1,
    StShowP1  = 3'd2,
    StShowP2  = 3'd3,
    StShowRes = 3'd4,
    StOver    = 3'd5
  } state_e;

  state_e            state_q, state_d;
  logic [TickW-1:0]  tick_cnt_q;
  logic [StabW-1:0]  stab_q, stab_d, stab_inc;
  logic [PhaseW-1:0] phase_q, phase_d;
  logic [2:0]        prev1_q, prev1_d, prev2_q, prev2_d;
  logic [2:0]        mv1_q, mv1_d, mv2_q, mv2_d;
  logic [3:0]        s1_q, s1_d, s2_q, s2_d;
  logic              tick, phase_last, both_valid;
  logic [2:0]        res_code;

  function automatic logic is_move(logic [2:0] m);
    return (m == Rock) || (m == Paper) || (m == Scissors);
  endfunction

  // Free-running prescaler; never cleared by new_game_i so tick cadence is undisturbed.
  assign tick = (tick_cnt_q == TickW'(TICK_DIV - 1));

  always_ff @(posedge clk_i or negedge reset_n) begin
    if (!reset_n) begin
      tick_cnt_q <= '0;
    end else begin
      tick_cnt_q <= tick ? '0 : tick_cnt_q + 1'b1;
    end
  end

  assign phase_last = (phase_q == PhaseW'(SHOW_TICKS - 1));
  assign both_valid = is_move(bus.p1_i) && is_move(bus.p2_i);

  always_comb begin
    res_code = ResP2;
    if (mv1_q == mv2_q) begin
      res_code = ResDraw;
    end else if ((mv1_q == Rock && mv2_q == Scissors) ||
                 (mv1_q == Scissors && mv2_q == Paper) ||
                 (mv1_q == Paper && mv2_q == Rock)) begin
      res_code = ResP1;
    end
  end

  always_comb begin
    state_d  = state_q;
    stab_d   = stab_q;
    phase_d  = phase_q;
    prev1_d  = prev1_q;
    prev2_d  = prev2_q;
    mv1_d    = mv1_q;
    mv2_d    = mv2_q;
    s1_d     = s1_q;
    s2_d     = s2_q;
    stab_inc = '0;

    if (bus.new_game_i) begin
      state_d = StRelease;
      stab_d  = '0;
      phase_d = '0;
      prev1_d = '0;
      prev2_d = '0;
      s1_d    = '0;
      s2_d    = '0;
    end else begin
      case (state_q)
        StRelease: begin
          if (tick && bus.p1_i == 3'b000 && bus.p2_i == 3'b000) begin
            state_d = StCollect;
            stab_d  = '0;
            prev1_d = '0;
            prev2_d = '0;
          end
        end
        StCollect: begin
          if (tick) begin
            prev1_d = bus.p1_i;
            prev2_d = bus.p2_i;
            if (both_valid && bus.p1_i == prev1_q && bus.p2_i == prev2_q) begin
              stab_inc = stab_q + 1'b1;
            end else if (both_valid) begin
              stab_inc = StabW'(1);
            end
            if (stab_inc == StabW'(STABLE_TICKS)) begin
              mv1_d   = bus.p1_i;
              mv2_d   = bus.p2_i;
              stab_d  = '0;
              phase_d = '0;
              state_d = StShowP1;
            end else begin
              stab_d = stab_inc;
            end
          end
        end
        StShowP1, StShowP2: begin
          if (tick) begin
            if (phase_last) begin
              phase_d = '0;
              state_d = (state_q == StShowP1) ? StShowP2 : StShowRes;
            end else begin
              phase_d = phase_q + 1'b1;
            end
          end
        end
        StShowRes: begin
          if (tick) begin
            if (phase_last) begin
              phase_d = '0;
              state_d = StRelease;
              // Reaching the target moves to OVER, so scores can never pass it.
              if (res_code == ResP1) begin
                s1_d = s1_q + 4'd1;
                if (s1_q + 4'd1 == WinTgt) state_d = StOver;
              end else if (res_code == ResP2) begin
                s2_d = s2_q + 4'd1;
                if (s2_q + 4'd1 == WinTgt) state_d = StOver;
              end
            end else begin
              phase_d = phase_q + 1'b1;
            end
          end
        end
        StOver: begin
          state_d = StOver;
        end
        default: begin
          state_d = StRelease;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StRelease;
      stab_q  <= '0;
      phase_q <= '0;
      prev1_q <= '0;
      prev2_q <= '0;
      mv1_q   <= '0;
      mv2_q   <= '0;
      s1_q    <= '0;
      s2_q    <= '0;
    end else begin
      state_q <= state_d;
      stab_q  <= stab_d;
      phase_q <= phase_d;
      prev1_q <= prev1_d;
      prev2_q <= prev2_d;
      mv1_q   <= mv1_d;
      mv2_q   <= mv2_d;
      s1_q    <= s1_d;
      s2_q    <= s2_d;
    end
  end

  always_comb begin
    bus.disp_sel_o  = 3'd0;
    bus.disp_data_o = 3'b000;
    bus.game_over_o = 1'b0;
    case (state_q)
      StShowP1: begin
        bus.disp_sel_o  = 3'd1;
        bus.disp_data_o = mv1_q;
      end
      StShowP2: begin
        bus.disp_sel_o  = 3'd2;
        bus.disp_data_o = mv2_q;
      end
      StShowRes: begin
        bus.disp_sel_o  = 3'd3;
        bus.disp_data_o = res_code;
      end
      StOver: begin
        bus.disp_sel_o  = 3'd4;
        bus.disp_data_o = (s1_q == WinTgt) ? ResP1 : ResP2;
        bus.game_over_o = 1'b1;
      end
      default: begin
        bus.disp_sel_o  = 3'd0;
      end
    endcase
  end

  assign bus.state_o    = state_q;
  assign bus.p1_score_o = s1_q;
  assign bus.p2_score_o = s2_q;

endmodule
